// File: rtl/serv_wakeup.sv
// Sleep/wake controller for the SERV core: owns the core clock enable and reports why the core woke.
// Optional sleep-length counter enabled by defining SERV_WAKEUP_SLEEP_COUNTER_EN.
module serv_wakeup #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WAKE_DELAY   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sleep_req,
  input  logic        i_timer_irq,
  input  logic        i_external_irq,
  output logic        o_clk_en,
  output logic        o_sleep_ack,
  output logic        o_wake,
  output logic [1:0]  o_wake_cause
`ifdef SERV_WAKEUP_SLEEP_COUNTER_EN
  ,
  output logic [31:0] o_sleep_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_t;

  localparam logic [7:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 8'(DRAIN_CYCLES - 1) : 8'd0;
  localparam logic [7:0] WAKE_LOAD  = (WAKE_DELAY > 0)   ? 8'(WAKE_DELAY - 1)   : 8'd0;

  state_t     state;
  logic [7:0] count;
  logic [1:0] irq_vec;
  logic       irq;
  logic       enter_sleep;

  assign irq_vec = {i_external_irq, i_timer_irq};
  assign irq     = |irq_vec;

  // Shared by the FSM and the sleep counter so both agree on the gating edge.
  always_comb begin
    enter_sleep = 1'b0;
    if (i_sleep_req && !irq) begin
      if (state == RUN && !o_wake && DRAIN_CYCLES == 0)
        enter_sleep = 1'b1;
      if (state == DRAIN && count == 8'd0)
        enter_sleep = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= RUN;
      count        <= 8'd0;
      o_clk_en     <= 1'b1;
      o_sleep_ack  <= 1'b0;
      o_wake       <= 1'b0;
      o_wake_cause <= 2'b00;
    end else begin
      o_wake <= 1'b0;
      case (state)
        RUN: begin
          // The o_wake cycle is a blackout so a wake pulse is never merged with a new request.
          if (!o_wake && i_sleep_req) begin
            if (irq) begin
              o_wake       <= 1'b1;
              o_wake_cause <= irq_vec;
            end else if (enter_sleep) begin
              state       <= SLEEP;
              o_clk_en    <= 1'b0;
              o_sleep_ack <= 1'b1;
            end else begin
              state <= DRAIN;
              count <= DRAIN_LOAD;
            end
          end
        end

        DRAIN: begin
          if (irq) begin
            state        <= RUN;
            o_wake       <= 1'b1;
            o_wake_cause <= irq_vec;
          end else if (!i_sleep_req) begin
            state <= RUN;
          end else if (enter_sleep) begin
            state       <= SLEEP;
            o_clk_en    <= 1'b0;
            o_sleep_ack <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end

        SLEEP: begin
          if (irq) begin
            o_wake_cause <= irq_vec;
            if (WAKE_DELAY > 0) begin
              state <= WAKE;
              count <= WAKE_LOAD;
            end else begin
              state       <= RUN;
              o_clk_en    <= 1'b1;
              o_sleep_ack <= 1'b0;
              o_wake      <= 1'b1;
            end
          end
        end

        WAKE: begin
          if (count == 8'd0) begin
            state       <= RUN;
            o_clk_en    <= 1'b1;
            o_sleep_ack <= 1'b0;
            o_wake      <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end

        default: begin
          state       <= RUN;
          count       <= 8'd0;
          o_clk_en    <= 1'b1;
          o_sleep_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERV_WAKEUP_SLEEP_COUNTER_EN
  // Cleared on entry to SLEEP so it holds the length of the latest sleep, WAKE included.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_sleep_cycles <= 32'd0;
    else if (enter_sleep)
      o_sleep_cycles <= 32'd0;
    else if (o_sleep_ack && o_sleep_cycles != 32'hFFFF_FFFF)
      o_sleep_cycles <= o_sleep_cycles + 32'd1;
  end
`endif

endmodule
